reg_bus_sequencer: RTL and testbench
====================================

Name: reg_bus_sequencer

Overview:
- Sequences all transfers on the shared 8-bit cpu_bus of the register bank: seven general registers (index 0-6) plus the accumulator (index 7).
- Arbitrates between two requesters: req0 is the instruction decoder, req1 is the debug/load port.
- Produces the one-hot read-enable and write-enable vectors that drive the register bank.
- Enforces bus discipline: at most one driver on the bus, a settle window before capture, and a dead turnaround cycle after every bus transfer.

Parameters:
- SETTLE_CYCLES, 1, number of cycles the source drives the bus before capture; legal range 1-4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_op  input  1  0 = MOVE, 1 = LOAD_ACC.
- req0_src  input  3  source register index (MOVE only).
- req0_dst  input  3  destination register index (MOVE only).
- req1_valid, req1_ready, req1_op, req1_src, req1_dst: same as req0, for requester 1.
- reg_read_en  output  8  one-hot; bit i lets register i drive cpu_bus.
- reg_write_en  output  8  one-hot; bit i captures into register i. Bit 7 loads the accumulator from its ALU input, not from the bus.
- done  output  1  one-cycle pulse when a command completes.
- done_id  output  1  requester whose command completed.
- err  output  1  one-cycle pulse when a command is rejected.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - reg_read_en = 0, reg_write_en = 0, done = 0, done_id = 0, err = 0, busy = 0.
  - last_grant = 1, so req0 wins the first contention.
- Registered outputs:
  - reg_read_en, reg_write_en, done, done_id, err and busy are all flops.
  - reqN_ready is combinational: it is high only in IDLE, for the granted requester whose valid is high.
- Arbitration (IDLE only):
  - If one requester is valid, it is granted.
  - If both are valid, grant the one not equal to last_grant.
  - last_grant updates on every acceptance.
  - A command is accepted on the edge where valid && ready. Its op, src and dst are captured into internal registers, together with its id.
- Validation at acceptance:
  - A MOVE with dst == 7 or src == dst is illegal.
  - An illegal command is still accepted (ready = 1). err pulses and done pulses (done_id = id) in the next cycle, no enables assert, and the FSM stays in IDLE.
- States: IDLE, DRIVE, CAPTURE, RELEASE, ACCLD.
- MOVE (legal), accepted at cycle T:
  - DRIVE, cycles T+1 .. T+SETTLE_CYCLES: reg_read_en = 1<<src. A down-counter tracks the cycles.
  - CAPTURE, cycle T+SETTLE_CYCLES+1: reg_read_en = 1<<src and reg_write_en = 1<<dst.
  - RELEASE, cycle T+SETTLE_CYCLES+2: both vectors = 0, done = 1, done_id = id.
  - IDLE from T+SETTLE_CYCLES+3; a new command can be accepted in that cycle.
- LOAD_ACC, accepted at T:
  - ACCLD, cycle T+1: reg_write_en = 8'h80, reg_read_en = 0, done = 1.
  - IDLE at T+2. No turnaround is needed because the bus is unused.
- busy = 1 in every state except IDLE.
- Invariants (checked by assertions):
  - reg_read_en is zero or one-hot; reg_write_en is zero or one-hot.
  - reg_read_en[i] and reg_write_en[i] are never both set.
  - reg_write_en is never nonzero unless the FSM is in CAPTURE or ACCLD.
- Input stability: an unaccepted requester's valid stays high and its fields are held stable. The block tolerates field changes while ready = 0 and samples only at acceptance.
- Reset mid-transfer: all enables drop asynchronously, nothing completes, and no done is issued.
- Simultaneous events: a newly arriving valid during any non-IDLE state is ignored until IDLE.

Test Plan:
- Reset, then req0 MOVE src=2 dst=5 (SETTLE_CYCLES=1), accepted at cycle 0 -> read_en=8'h04 in cycles 1-2, write_en=8'h20 in cycle 2, all zero plus done=1/done_id=0 in cycle 3, req0_ready usable again at cycle 4.
- req0 LOAD_ACC -> write_en=8'h80 for exactly one cycle with read_en=0; done in the same cycle; next acceptance is possible 2 cycles after the first.
- Both requesters continuously valid with MOVE commands after reset -> grants alternate 0,1,0,1; each done_id matches its grant; busy stays high except in the single IDLE cycle between commands.
- Illegal commands: req1 MOVE src=3 dst=3, then MOVE src=1 dst=7 -> each accepted, err=1 and done=1 the next cycle, read_en/write_en stay 8'h00 throughout.
- SETTLE_CYCLES=3, MOVE src=7 dst=0 -> read_en=8'h80 for cycles 1-4, write_en=8'h01 in cycle 4 only, done in cycle 5.
- Assert rst=0 during CAPTURE of a MOVE -> enables go to 0 immediately without waiting for a clock edge, no done; after release the next request is granted to req0.

Source files
------------

// File: rtl/reg_bus_sequencer.sv
// Bus sequencer for the 8-entry register bank: it arbitrates two requesters and
// steps each MOVE through drive, settle, capture and a dead turnaround cycle.
module reg_bus_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_op,
    input  logic [2:0] req0_src,
    input  logic [2:0] req0_dst,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_op,
    input  logic [2:0] req1_src,
    input  logic [2:0] req1_dst,
    output logic [7:0] reg_read_en,
    output logic [7:0] reg_write_en,
    output logic       done,
    output logic       done_id,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        RELEASE,
        ACCLD
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       op_q, op_d;
    logic [2:0] src_q, src_d;
    logic [2:0] dst_q, dst_d;
    logic       id_q, id_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] read_en_q, read_en_d;
    logic [7:0] write_en_q, write_en_d;
    logic       done_q, done_d;
    logic       done_id_q, done_id_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    logic       grant0, grant1, accept, illegal;
    logic       sel_op;
    logic [2:0] sel_src, sel_dst;

    // On contention, the requester that did not win last time goes first.
    always_comb begin
        grant0  = req0_valid && (!req1_valid || last_grant_q);
        grant1  = req1_valid && !grant0;
        req0_ready = (state_q == IDLE) && grant0;
        req1_ready = (state_q == IDLE) && grant1;
        accept  = req0_ready || req1_ready;
        sel_op  = grant0 ? req0_op  : req1_op;
        sel_src = grant0 ? req0_src : req1_src;
        sel_dst = grant0 ? req0_dst : req1_dst;
        illegal = !sel_op && ((sel_dst == 3'd7) || (sel_src == sel_dst));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        src_d        = src_q;
        dst_d        = dst_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant1;
                    op_d         = sel_op;
                    src_d        = sel_src;
                    dst_d        = sel_dst;
                    id_d         = grant1;
                    if (illegal) begin
                        err_d     = 1'b1;
                        done_d    = 1'b1;
                        done_id_d = grant1;
                    end else if (sel_op) begin
                        state_d   = ACCLD;
                        done_d    = 1'b1;
                        done_id_d = grant1;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 2'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            CAPTURE: begin
                state_d   = RELEASE;
                done_d    = 1'b1;
                done_id_d = id_q;
            end
            RELEASE: state_d = IDLE;
            ACCLD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enables are decoded from the next state so the registered vectors line up with state_q.
    always_comb begin
        read_en_d  = 8'h00;
        write_en_d = 8'h00;
        if ((state_d == DRIVE) || (state_d == CAPTURE)) begin
            read_en_d = 8'h01 << src_d;
        end
        if (state_d == CAPTURE) begin
            write_en_d = 8'h01 << dst_d;
        end else if (state_d == ACCLD) begin
            write_en_d = 8'h80;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            op_q         <= 1'b0;
            src_q        <= 3'd0;
            dst_q        <= 3'd0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            read_en_q    <= 8'h00;
            write_en_q   <= 8'h00;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            read_en_q    <= read_en_d;
            write_en_q   <= write_en_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign reg_read_en  = read_en_q;
    assign reg_write_en = write_en_q;
    assign done         = done_q;
    assign done_id      = done_id_q;
    assign err          = err_q;
    assign busy         = busy_q;

    // Bus discipline: a single driver, a single capturer, never the same register.
    a_read_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(reg_read_en));
    a_write_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(reg_write_en));
    a_no_self: assert property (@(posedge clk) disable iff (!rst)
        (reg_read_en & reg_write_en) == 8'h00);
    a_write_state: assert property (@(posedge clk) disable iff (!rst)
        (reg_write_en != 8'h00) |-> ((state_q == CAPTURE) || (state_q == ACCLD)));

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Directed bench for reg_bus_sequencer: one instance with SETTLE_CYCLES=1 for most
// scenarios and a second with SETTLE_CYCLES=3 for the long settle window.
module tb_reg_bus_sequencer;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready, req0_op;
    logic [2:0] req0_src, req0_dst;
    logic       req1_valid, req1_ready, req1_op;
    logic [2:0] req1_src, req1_dst;
    logic [7:0] reg_read_en, reg_write_en;
    logic       done, done_id, err, busy;

    logic       b_req0_valid, b_req0_ready, b_req0_op;
    logic [2:0] b_req0_src, b_req0_dst;
    logic       b_req1_valid, b_req1_ready, b_req1_op;
    logic [2:0] b_req1_src, b_req1_dst;
    logic [7:0] b_read_en, b_write_en;
    logic       b_done, b_done_id, b_err, b_busy;

    int total;
    int bad;

    reg_bus_sequencer #(.SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src(req0_src), .req0_dst(req0_dst),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src(req1_src), .req1_dst(req1_dst),
        .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
        .done(done), .done_id(done_id), .err(err), .busy(busy)
    );

    reg_bus_sequencer #(.SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
        .req0_src(b_req0_src), .req0_dst(b_req0_dst),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
        .req1_src(b_req1_src), .req1_dst(b_req1_dst),
        .reg_read_en(b_read_en), .reg_write_en(b_write_en),
        .done(b_done), .done_id(b_done_id), .err(b_err), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit which, input logic valid, input logic op,
                                 input logic [2:0] src, input logic [2:0] dst);
        if (which == 1'b0) begin
            req0_valid = valid; req0_op = op; req0_src = src; req0_dst = dst;
        end else begin
            req1_valid = valid; req1_op = op; req1_src = src; req1_dst = dst;
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_rd, exp_wr;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        b_req0_valid = 0; b_req0_op = 0; b_req0_src = 0; b_req0_dst = 0;
        b_req1_valid = 0; b_req1_op = 0; b_req1_src = 0; b_req1_dst = 0;

        repeat (2) next_cycle();
        checkOutput("rst_read", reg_read_en, 8'h00);
        checkOutput("rst_write", reg_write_en, 8'h00);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_done_id", done_id, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b1;

        // MOVE src=2 dst=5, accepted in cycle 0
        next_cycle();
        applyStimulus(0, 1, 0, 3'd2, 3'd5);
        #1;
        checkOutput("mv_ready0", req0_ready, 1);
        checkOutput("mv_ready1", req1_ready, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mv_c1_read", reg_read_en, 8'h04);
        checkOutput("mv_c1_write", reg_write_en, 8'h00);
        checkOutput("mv_c1_busy", busy, 1);
        next_cycle();
        checkOutput("mv_c2_read", reg_read_en, 8'h04);
        checkOutput("mv_c2_write", reg_write_en, 8'h20);
        checkOutput("mv_c2_done", done, 0);
        next_cycle();
        checkOutput("mv_c3_read", reg_read_en, 8'h00);
        checkOutput("mv_c3_write", reg_write_en, 8'h00);
        checkOutput("mv_c3_done", done, 1);
        checkOutput("mv_c3_done_id", done_id, 0);
        checkOutput("mv_c3_busy", busy, 1);

        // LOAD_ACC back to back, accepted at cycle 4 and again at cycle 6
        next_cycle();
        checkOutput("mv_c4_busy", busy, 0);
        checkOutput("mv_c4_done", done, 0);
        applyStimulus(0, 1, 1, 0, 0);
        #1;
        checkOutput("la_ready_c4", req0_ready, 1);
        next_cycle();
        checkOutput("la_c5_write", reg_write_en, 8'h80);
        checkOutput("la_c5_read", reg_read_en, 8'h00);
        checkOutput("la_c5_done", done, 1);
        checkOutput("la_c5_done_id", done_id, 0);
        checkOutput("la_c5_busy", busy, 1);
        checkOutput("la_ready_c5", req0_ready, 0);
        next_cycle();
        checkOutput("la_c6_write", reg_write_en, 8'h00);
        checkOutput("la_c6_done", done, 0);
        checkOutput("la_c6_busy", busy, 0);
        checkOutput("la_ready_c6", req0_ready, 1);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("la_c7_write", reg_write_en, 8'h80);
        checkOutput("la_c7_done", done, 1);
        next_cycle();
        checkOutput("la_c8_write", reg_write_en, 8'h00);
        checkOutput("la_c8_busy", busy, 0);

        // Contention after reset: grants alternate 0,1,0,1
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        applyStimulus(0, 1, 0, 3'd0, 3'd1);
        applyStimulus(1, 1, 0, 3'd4, 3'd6);
        for (int g = 0; g < 4; g++) begin
            #1;
            exp_rd = (g % 2 == 0) ? 8'h01 : 8'h10;
            exp_wr = (g % 2 == 0) ? 8'h02 : 8'h40;
            checkOutput($sformatf("arb%0d_idle_busy", g), busy, 0);
            checkOutput($sformatf("arb%0d_ready0", g), req0_ready, (g % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("arb%0d_ready1", g), req1_ready, (g % 2 == 1) ? 1 : 0);
            next_cycle();
            checkOutput($sformatf("arb%0d_drv_read", g), reg_read_en, exp_rd);
            checkOutput($sformatf("arb%0d_drv_busy", g), busy, 1);
            next_cycle();
            checkOutput($sformatf("arb%0d_cap_read", g), reg_read_en, exp_rd);
            checkOutput($sformatf("arb%0d_cap_write", g), reg_write_en, exp_wr);
            next_cycle();
            checkOutput($sformatf("arb%0d_done", g), done, 1);
            checkOutput($sformatf("arb%0d_done_id", g), done_id, g % 2);
            checkOutput($sformatf("arb%0d_rel_busy", g), busy, 1);
            next_cycle();
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        // Illegal MOVEs from req1: src==dst, then dst==7
        next_cycle();
        applyStimulus(1, 1, 0, 3'd3, 3'd3);
        #1;
        checkOutput("ill1_ready1", req1_ready, 1);
        next_cycle();
        checkOutput("ill1_err", err, 1);
        checkOutput("ill1_done", done, 1);
        checkOutput("ill1_done_id", done_id, 1);
        checkOutput("ill1_read", reg_read_en, 8'h00);
        checkOutput("ill1_write", reg_write_en, 8'h00);
        checkOutput("ill1_busy", busy, 0);
        applyStimulus(1, 1, 0, 3'd1, 3'd7);
        #1;
        checkOutput("ill2_ready1", req1_ready, 1);
        next_cycle();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("ill2_err", err, 1);
        checkOutput("ill2_done", done, 1);
        checkOutput("ill2_done_id", done_id, 1);
        checkOutput("ill2_read", reg_read_en, 8'h00);
        checkOutput("ill2_write", reg_write_en, 8'h00);
        next_cycle();
        checkOutput("ill_after_err", err, 0);
        checkOutput("ill_after_done", done, 0);

        // Reset asserted during CAPTURE of a req1 MOVE
        applyStimulus(1, 1, 0, 3'd0, 3'd2);
        #1;
        checkOutput("rm_ready1", req1_ready, 1);
        next_cycle();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rm_drv_read", reg_read_en, 8'h01);
        next_cycle();
        checkOutput("rm_cap_read", reg_read_en, 8'h01);
        checkOutput("rm_cap_write", reg_write_en, 8'h04);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rm_async_read", reg_read_en, 8'h00);
        checkOutput("rm_async_write", reg_write_en, 8'h00);
        checkOutput("rm_async_busy", busy, 0);
        next_cycle();
        checkOutput("rm_hold_done", done, 0);
        rst = 1'b1;
        next_cycle();
        checkOutput("rm_rel_done", done, 0);
        checkOutput("rm_rel_busy", busy, 0);
        applyStimulus(0, 1, 0, 3'd2, 3'd5);
        applyStimulus(1, 1, 0, 3'd4, 3'd6);
        #1;
        checkOutput("rm_grant_ready0", req0_ready, 1);
        checkOutput("rm_grant_ready1", req1_ready, 0);
        next_cycle();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rm_next_read", reg_read_en, 8'h04);
        next_cycle();
        next_cycle();
        checkOutput("rm_next_done", done, 1);
        checkOutput("rm_next_done_id", done_id, 0);
        next_cycle();

        // SETTLE_CYCLES=3 instance: MOVE src=7 dst=0
        b_req0_valid = 1; b_req0_op = 0; b_req0_src = 3'd7; b_req0_dst = 3'd0;
        #1;
        checkOutput("s3_ready0", b_req0_ready, 1);
        checkOutput("s3_ready1", b_req1_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 1) b_req0_valid = 0;
            checkOutput($sformatf("s3_c%0d_read", k), b_read_en, 8'h80);
            checkOutput($sformatf("s3_c%0d_write", k), b_write_en, (k == 4) ? 8'h01 : 8'h00);
            checkOutput($sformatf("s3_c%0d_done", k), b_done, 0);
        end
        next_cycle();
        checkOutput("s3_c5_done", b_done, 1);
        checkOutput("s3_c5_done_id", b_done_id, 0);
        checkOutput("s3_c5_err", b_err, 0);
        checkOutput("s3_c5_read", b_read_en, 8'h00);
        checkOutput("s3_c5_write", b_write_en, 8'h00);
        next_cycle();
        checkOutput("s3_c6_busy", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
